kc87_int_ctrl: RTL
==================

// Module: kc87_int_ctrl
// PURPOSE
//   Parametrised Z80 mode-2 interrupt controller sitting between the KC87
//   peripherals (PIO/CTC/keyboard) and the T80 core. Latches up to N_CH
//   requests, resolves fixed priority (ch0 highest) with nesting, drives
//   INT_n, supplies the vector during the INTA cycle, and retires service
//   on RETI. Adds mask, edge/level mode and computed vectors.
// PARAMETERS
//   N_CH       8     number of request channels (1..16)
//   EDGE_TRIG  1     1: rising edge of int_periph sets pending; 0: level
//   VEC_MODE   0     0: vector from vec_in slice; 1: VEC_BASE | (ch<<1)
//   VEC_BASE   8'h80 base vector for VEC_MODE=1 (bit0 forced 0)
// PORTS
//   clk         in   1        system clock (same as T80 CLK_n)
//   res_n       in   1        async active-low reset
//   int_periph  in   N_CH     peripheral request lines
//   int_en      in   N_CH     per-channel enable mask (1=enabled)
//   vec_in      in   8*N_CH   per-channel vector, ch k at [8k+7:8k]
//   m1_n        in   1        T80 M1_n
//   iorq_n      in   1        T80 IORQ_n
//   reti_n      in   1        T80 RETI_n (low pulse on RETI decode)
//   int_n       out  1        to T80 INT_n, active low
//   int_ack     out  N_CH     one-cycle pulse on granted channel
//   cpu_di      out  8        vector to CPU data mux
//   vec_oe      out  1        1 while cpu_di must be selected by the mux
//   pending     out  N_CH     latched requests (debug/status)
//   in_service  out  N_CH     channels in service (debug/status)
// BEHAVIOUR
//   Reset (async, res_n=0): int_n=1, int_ack=0, cpu_di=0, vec_oe=0,
//     pending=0, in_service=0, state=IDLE, edge/RETI history regs=0.
//   Pending: EDGE_TRIG=1 sets bit k the cycle after int_periph[k] 0->1
//     (registered sample). EDGE_TRIG=0 sets bit k when int_periph[k]=1 and
//     in_service[k]=0. Cleared only by grant; set wins on same-cycle grant.
//   Eligible: e = pending & int_en. Winner = lowest set index of e.
//     Raise allowed only if winner index < lowest set index of in_service
//     (empty in_service => always allowed).
//   FSM states IDLE, REQ, ACK:
//     IDLE: int_n=1. Eligible winner allowed -> REQ (int_n=0 registered,
//       i.e. request edge to int_n low = 2 clk).
//     REQ: int_n=0. Winner lost (masked/not allowed) -> IDLE, int_n=1.
//       INTA seen (m1_n=0 & iorq_n=0) -> ACK; grant index frozen that cycle.
//     ACK: int_n=1, vec_oe=1, cpu_di=vector of frozen channel, stable for
//       whole ACK. Entry cycle: int_ack[g]=1 for exactly 1 clk,
//       pending[g]<=0, in_service[g]<=1. m1_n=1 or iorq_n=1 -> IDLE,
//       vec_oe=0 next clk.
//   Vector: VEC_MODE=0 -> vec_in[8g+7:8g]; VEC_MODE=1 -> VEC_BASE&8'hFE |
//     (g<<1), 8-bit wrap on overflow.
//   RETI: falling edge of reti_n clears lowest set bit of in_service; no
//     effect when in_service=0. RETI and grant same cycle: both applied.
//   Plain I/O cycles (iorq_n=0, m1_n=1) never count as INTA.
//   Reset mid-ACK: everything returns to reset values immediately.
// TESTING
//   1 VEC_MODE=0, vec_in ch3=8'hE6, pulse int_periph[3] -> int_n low 2 clk
//     later; INTA -> cpu_di=E6, vec_oe=1, int_ack=08 one clk, in_service=08.
//   2 ch1 and ch5 edges same clk -> ch1 granted, pending=20; RETI pulse ->
//     in_service=0, int_n low again, second INTA grants ch5.
//   3 in_service=10 (ch4): request ch6 -> int_n stays 1; request ch2 ->
//     int_n low, INTA -> in_service=14; RETI clears bit2 first.
//   4 int_en[3]=0, edge ch3 -> pending=08, int_n=1; set int_en[3] -> int_n
//     low 1 clk later; clear mask in REQ -> back to IDLE, int_n=1.
//   5 VEC_MODE=1, VEC_BASE=80, grant ch3 -> cpu_di=86; EDGE_TRIG=0, held
//     level ch0 -> re-pends only after RETI.
//   6 res_n low during ACK -> int_n=1, vec_oe=0, pending=in_service=0; I/O
//     cycle with m1_n=1 in REQ -> no grant.

Source files
------------

// File: rtl/kc87_int_ctrl.sv
// kc87_int_ctrl: Z80 mode-2 interrupt controller for the KC87 (T80 core).
// Latches peripheral requests and resolves fixed, nested priority.
//
// Ports:
//   clk        in   system clock (T80 CLK_n domain)
//   res_n      in   async active-low reset
//   int_periph in   N_CH peripheral request lines
//   int_en     in   N_CH per-channel enable mask (1 = enabled)
//   vec_in     in   8*N_CH per-channel vectors, ch k at [8k+7:8k]
//   m1_n       in   T80 M1_n
//   iorq_n     in   T80 IORQ_n
//   reti_n     in   T80 RETI_n, low pulse on RETI decode
//   int_n      out  T80 INT_n, active low
//   int_ack    out  one-cycle pulse on the granted channel
//   cpu_di     out  vector for the CPU data mux
//   vec_oe     out  select for cpu_di at the CPU data mux
//   pending    out  latched requests
//   in_service out  channels currently in service
module kc87_int_ctrl #(
    parameter int         N_CH      = 8,
    parameter int         EDGE_TRIG = 1,
    parameter int         VEC_MODE  = 0,
    parameter logic [7:0] VEC_BASE  = 8'h80
) (
    input  logic              clk,
    input  logic              res_n,
    input  logic [N_CH-1:0]   int_periph,
    input  logic [N_CH-1:0]   int_en,
    input  logic [8*N_CH-1:0] vec_in,
    input  logic              m1_n,
    input  logic              iorq_n,
    input  logic              reti_n,
    output logic              int_n,
    output logic [N_CH-1:0]   int_ack,
    output logic [7:0]        cpu_di,
    output logic              vec_oe,
    output logic [N_CH-1:0]   pending,
    output logic [N_CH-1:0]   in_service
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_ACK
    } state_e;

    localparam logic [N_CH-1:0] ONE = N_CH'(1);

    state_e          state_q;
    logic            int_n_q;
    logic [N_CH-1:0] int_ack_q;
    logic [7:0]      cpu_di_q;
    logic            vec_oe_q;

    logic [N_CH-1:0] periph_q;
    logic            reti_q;
    logic [N_CH-1:0] pend_q;
    logic [N_CH-1:0] pend_d;
    logic [N_CH-1:0] isv_q;
    logic [N_CH-1:0] isv_d;

    logic [N_CH-1:0] elig;
    logic [N_CH-1:0] win_oh;
    logic [N_CH-1:0] isv_oh;
    logic [N_CH-1:0] grant_oh;
    logic [N_CH-1:0] set_v;
    logic [N_CH-1:0] reti_clr;
    logic [3:0]      win_idx;
    logic [7:0]      vec_w;
    logic            req_ok;
    logic            inta;
    logic            grant;
    logic            reti_fall;

    // Priority resolution. x & -x isolates the lowest set bit, so
    // comparing two one-hot words numerically compares their indices.
    always_comb begin
        elig   = pend_q & int_en;
        win_oh = elig & (~elig + ONE);
        isv_oh = isv_q & (~isv_q + ONE);
        req_ok = (|elig) && ((isv_q == '0) || (win_oh < isv_oh));
        win_idx = '0;
        for (int k = N_CH - 1; k >= 0; k--) begin
            if (elig[k]) begin
                win_idx = 4'(k);
            end
        end
    end

    always_comb begin
        vec_w = '0;
        if (VEC_MODE != 0) begin
            vec_w = (VEC_BASE & 8'hFE) | {3'b000, win_idx, 1'b0};
        end else begin
            vec_w = vec_in[8*int'(win_idx) +: 8];
        end
    end

    // Plain I/O cycles (m1_n high) never qualify as INTA.
    assign inta  = ~m1_n & ~iorq_n;
    assign grant = (state_q == S_REQ) && inta && req_ok;

    always_comb begin
        grant_oh  = grant ? win_oh : '0;
        reti_fall = reti_q & ~reti_n;
        reti_clr  = reti_fall ? isv_oh : '0;
        isv_d     = (isv_q & ~reti_clr) | grant_oh;
        // Level mode looks at the post-grant in-service set so a held
        // line cannot re-pend until its RETI.
        if (EDGE_TRIG != 0) begin
            set_v = int_periph & ~periph_q;
        end else begin
            set_v = int_periph & ~(isv_q | grant_oh);
        end
        // A new request beats a same-cycle grant clear.
        pend_d = (pend_q & ~grant_oh) | set_v;
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state_q   <= S_IDLE;
            int_n_q   <= 1'b1;
            int_ack_q <= '0;
            cpu_di_q  <= '0;
            vec_oe_q  <= 1'b0;
            periph_q  <= '0;
            reti_q    <= 1'b0;
            pend_q    <= '0;
            isv_q     <= '0;
        end else begin
            periph_q  <= int_periph;
            reti_q    <= reti_n;
            pend_q    <= pend_d;
            isv_q     <= isv_d;
            int_ack_q <= grant_oh;
            unique case (state_q)
                S_IDLE: begin
                    if (req_ok) begin
                        state_q <= S_REQ;
                        int_n_q <= 1'b0;
                    end
                end
                S_REQ: begin
                    if (!req_ok) begin
                        state_q <= S_IDLE;
                        int_n_q <= 1'b1;
                    end else if (inta) begin
                        state_q  <= S_ACK;
                        int_n_q  <= 1'b1;
                        vec_oe_q <= 1'b1;
                        cpu_di_q <= vec_w;
                    end
                end
                S_ACK: begin
                    if (m1_n || iorq_n) begin
                        state_q  <= S_IDLE;
                        vec_oe_q <= 1'b0;
                        cpu_di_q <= '0;
                    end
                end
                default: begin
                    state_q  <= S_IDLE;
                    int_n_q  <= 1'b1;
                    vec_oe_q <= 1'b0;
                    cpu_di_q <= '0;
                end
            endcase
        end
    end

    assign int_n      = int_n_q;
    assign int_ack    = int_ack_q;
    assign cpu_di     = cpu_di_q;
    assign vec_oe     = vec_oe_q;
    assign pending    = pend_q;
    assign in_service = isv_q;

endmodule
